fila_entrada: RTL

First-word-fall-through operand queue that sits directly upstream of the X register (data bus register) of the accumulator CPU. It accepts 4-bit operands from an external producer via a valid/ready handshake. It presents the oldest operand on `entrada`, and retires it on every clock edge where the control FSM drives `tx` = LOAD. This decouples operand arrival from the fixed state sequence of the control unit.

---
 rtl/fila_entrada_pkg.sv | 26 ++
 rtl/fila_entrada_if.sv | 33 +++
 rtl/fila_entrada.sv | 92 +++++++++
 3 files changed

// File: rtl/fila_entrada_pkg.sv
// Shared definitions for the accumulator CPU operand path.
// cpu_pkg     : X-register control codes driven by the control FSM (tx bus).
// fila_entrada_pkg : queue defaults and the occupancy-width helper.

package cpu_pkg;

  // X-register control codes; every block that decodes tx imports these.
  localparam logic [3:0] CLEAR  = 4'd0;
  localparam logic [3:0] LOAD   = 4'd1;
  localparam logic [3:0] HOLD   = 4'd2;
  localparam logic [3:0] SHIFTR = 4'd3;

endpackage : cpu_pkg

package fila_entrada_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;

  // Pointer/occupancy width: one bit more than the address so that a full
  // queue (count == depth) is distinguishable from an empty one.
  function automatic int cw_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fila_entrada_pkg

// File: rtl/fila_entrada_if.sv
// Operand queue bus: producer handshake, control code in, head operand and
// status out.
// master : producer + control FSM side; slave : the queue itself.

interface fila_entrada_if
  import fila_entrada_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = cw_of(DEPTH)
);

  logic [WIDTH-1:0] dado_in;     // operand offered by the producer
  logic             dado_valid;  // producer has an operand
  logic             dado_ready;  // queue can take it
  logic [3:0]       tx;          // X-register control code
  logic [WIDTH-1:0] entrada;     // head operand to the X register
  logic             vazio;       // queue empty
  logic             cheio;       // queue full
  logic [CW-1:0]    contagem;    // occupancy 0..DEPTH
  logic             underflow;   // sticky: LOAD seen while empty

  modport master (
    output dado_in, dado_valid, tx,
    input  dado_ready, entrada, vazio, cheio, contagem, underflow
  );

  modport slave (
    input  dado_in, dado_valid, tx,
    output dado_ready, entrada, vazio, cheio, contagem, underflow
  );

endinterface : fila_entrada_if

// File: rtl/fila_entrada.sv
// First-word-fall-through operand queue feeding the X register.
// Ports: clock, reset_n (sync, active-low), bus (fila_entrada_if.slave).
// Latency: a push into an empty queue shows on entrada after the same edge;
// a LOAD retires the head on its edge. Backpressure: dado_ready = !cheio,
// taken only from the pointer registers.

module fila_entrada
  import cpu_pkg::*;
  import fila_entrada_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  fila_entrada_if.slave     bus
);

  localparam int CW = cw_of(DEPTH);
  localparam int AW = CW - 1;

  // Pointer registers carry one extra wrap bit above the address.
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             vazio;
  logic             cheio;
  logic             is_load;
  logic             push;
  logic             pop;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Status is purely a function of the pointers, never of valid or tx.
  assign vazio = (wr_ptr_q == rd_ptr_q);
  assign cheio = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign is_load = (bus.tx == LOAD);

  // A full queue refuses pushes even if the head retires on the same edge;
  // the slot frees up one cycle later.
  assign push = bus.dado_valid && !cheio;
  // A LOAD on an empty queue does not pop, even if a word is pushed on the
  // same edge: that word only becomes the head after the edge.
  assign pop  = is_load && !vazio;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (is_load && vazio) begin
      underflow_d = 1'b1;
    end
  end

  // Storage is deliberately not cleared by reset; only pointers and the flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      underflow_q <= underflow_d;
      if (push) begin
        mem_q[wr_idx] <= bus.dado_in;
      end
    end
  end

  assign bus.vazio      = vazio;
  assign bus.cheio      = cheio;
  assign bus.dado_ready = !cheio;
  assign bus.contagem   = wr_ptr_q - rd_ptr_q;
  assign bus.underflow  = underflow_q;
  // Empty queue presents zero so an underflowed LOAD behaves like CLEAR.
  assign bus.entrada    = vazio ? '0 : mem_q[rd_idx];

endmodule : fila_entrada
